// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one memory op from execute, checks alignment and
// the ROM/RAM map, runs a single req/ack bus transaction and hands the
// extended load data (or a fault) back to writeback.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new request from execute
// BUS   | bus_req held with stable address/data until bus_ack or timeout
// RESP  | one-cycle wb_valid pulse carrying wb_rdata/fault
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] FAULT_DATA     = 32'hdead_beef
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [2:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        wb_valid,
    output logic [31:0] wb_rdata,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // mem_read_t encoding
    localparam logic [2:0] RD_NONE   = 3'd0;
    localparam logic [2:0] RD_BYTE   = 3'd1;
    localparam logic [2:0] RD_HALF   = 3'd2;
    localparam logic [2:0] RD_WORD   = 3'd3;
    localparam logic [2:0] RD_BYTE_U = 3'd4;
    localparam logic [2:0] RD_HALF_U = 3'd5;
    // mem_write_t encoding
    localparam logic [1:0] WR_NONE   = 2'd0;
    localparam logic [1:0] WR_BYTE   = 2'd1;
    localparam logic [1:0] WR_HALF   = 2'd2;
    localparam logic [1:0] WR_WORD   = 2'd3;

    localparam logic [31:0] RAM_BASE = 32'h0000_1000;
    localparam logic [31:0] MEM_END  = 32'h0000_3000;

    // Timer counts down from TIMEOUT_CYCLES-1; terminal count 0 ends BUS.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [TW-1:0] tmr_q;
    logic [2:0]  ld_op_q;
    logic [1:0]  ld_ofs_q;
    logic        fault_q;
    logic [31:0] wb_rdata_q;

    logic        is_rd, is_wr, is_half, is_word, rd_illegal;
    logic        chk_fault, accept, timeout_hit;
    logic        resp_en, resp_fault_d;
    logic [31:0] resp_data_d;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_lane;
    logic [31:0] ld_ext;

    assign ex_ready = (state_q == S_IDLE);
    assign bus_req  = (state_q == S_BUS);
    assign wb_valid = (state_q == S_RESP);
    assign fault    = fault_q;
    assign wb_rdata = wb_rdata_q;

    // Request decode and legality checks, evaluated on the incoming op.
    always_comb begin
        is_rd      = (mem_read != RD_NONE);
        is_wr      = (mem_write != WR_NONE);
        // Codes 6/7 are not valid loads; they fault rather than silently act as NONE.
        rd_illegal = (mem_read > RD_HALF_U);
        is_half    = (mem_read == RD_HALF) || (mem_read == RD_HALF_U) || (mem_write == WR_HALF);
        is_word    = (mem_read == RD_WORD) || (mem_write == WR_WORD);
        chk_fault  = (is_rd && is_wr)
                   || rd_illegal
                   || (is_half && addr[0])
                   || (is_word && (addr[1:0] != 2'b00))
                   || (is_rd && (addr >= MEM_END))
                   || (is_wr && ((addr < RAM_BASE) || (addr >= MEM_END)));
        accept     = (state_q == S_IDLE) && ex_valid && (is_rd || is_wr);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tmr_q == '0);
    end

    // Store lane steering: replicate data across lanes, enable only the target bytes.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = wdata;
        case (mem_write)
            WR_BYTE: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            WR_HALF: begin
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata[15:0]}};
            end
            WR_WORD: begin
                st_be    = 4'b1111;
                st_wdata = wdata;
            end
            default: begin
                st_be    = 4'b0000;
                st_wdata = 32'h0;
            end
        endcase
    end

    // Load extract: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        ld_lane = bus_rdata >> {ld_ofs_q, 3'b000};
        ld_ext  = 32'h0;
        case (ld_op_q)
            RD_BYTE:   ld_ext = {{24{ld_lane[7]}}, ld_lane[7:0]};
            RD_HALF:   ld_ext = {{16{ld_lane[15]}}, ld_lane[15:0]};
            RD_WORD:   ld_ext = bus_rdata;
            RD_BYTE_U: ld_ext = {24'h0, ld_lane[7:0]};
            RD_HALF_U: ld_ext = {16'h0, ld_lane[15:0]};
            default:   ld_ext = 32'h0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the response that is captured on entry to RESP.
    always_comb begin
        state_d      = state_q;
        resp_en      = 1'b0;
        resp_fault_d = 1'b0;
        resp_data_d  = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (chk_fault) begin
                        state_d      = S_RESP;
                        resp_en      = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_data_d  = FAULT_DATA;
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // An ack on the terminal-count cycle still completes normally.
                if (bus_ack) begin
                    state_d     = S_RESP;
                    resp_en     = 1'b1;
                    resp_data_d = ld_ext;
                end else if (timeout_hit) begin
                    state_d      = S_RESP;
                    resp_en      = 1'b1;
                    resp_fault_d = 1'b1;
                    resp_data_d  = FAULT_DATA;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Latch the bus transaction on a legal accept, run the timer, capture the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_be     <= 4'b0000;
            ld_op_q    <= RD_NONE;
            ld_ofs_q   <= 2'b00;
            tmr_q      <= '0;
            fault_q    <= 1'b0;
            wb_rdata_q <= 32'h0;
        end else begin
            if (accept && !chk_fault) begin
                bus_we    <= is_wr;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_wdata <= st_wdata;
                bus_be    <= st_be;
                ld_op_q   <= mem_read;
                ld_ofs_q  <= addr[1:0];
                tmr_q     <= TMR_LOAD;
            end else if ((state_q == S_BUS) && (tmr_q != '0)) begin
                tmr_q <= tmr_q - TW'(1);
            end
            if (resp_en) begin
                fault_q    <= resp_fault_d;
                wb_rdata_q <= resp_data_d;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases from the plan followed by random
// ops, each predicted by a transaction-level model of the access rules.
module tb_lsu_mem_ctrl;

    localparam int          TMO   = 16;
    localparam logic [31:0] FDATA = 32'hdead_beef;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_vec = 0;
    int n_err = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TMO), .FAULT_DATA(FDATA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .wb_valid  (wb_valid),
        .wb_rdata  (wb_rdata),
        .fault     (fault),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: outcome of one access from the address-map and lane rules.
    function automatic void predict(input logic [2:0] rd, input logic [1:0] wr,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    input logic [31:0] rdata,
                                    output bit flt, output logic [3:0] be,
                                    output logic [31:0] bwd, output logic [31:0] rres);
        bit half, word;
        logic [31:0] sh, b, h;
        half = (rd == 3'd2) || (rd == 3'd5) || (wr == 2'd2);
        word = (rd == 3'd3) || (wr == 2'd3);
        flt  = ((rd != 0) && (wr != 0)) || (half && a[0]) || (word && (a[1:0] != 0))
            || ((rd != 0) && (a >= 32'h3000))
            || ((wr != 0) && ((a < 32'h1000) || (a >= 32'h3000)));
        be   = (wr == 2'd1) ? (4'b0001 << a[1:0]) :
               (wr == 2'd2) ? (4'b0011 << a[1:0]) :
               (wr == 2'd3) ? 4'b1111 : 4'b0000;
        bwd  = (wr == 2'd1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
               (wr == 2'd2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
        sh   = rdata >> (8 * a[1:0]);
        b    = sh & 32'hff;
        h    = sh & 32'hffff;
        case (rd)
            3'd1:    rres = b - ((b & 32'h80) << 1);
            3'd2:    rres = h - ((h & 32'h8000) << 1);
            3'd3:    rres = rdata;
            3'd4:    rres = b;
            3'd5:    rres = h;
            default: rres = 32'h0;
        endcase
    endfunction

    // One access starting at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_op(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_dly, input logic [31:0] rdata);
        bit          flt, tmo;
        logic [3:0]  e_be;
        logic [31:0] e_bwd, e_res, e_wb;
        int          ncyc;
        predict(rd, wr, a, wd, rdata, flt, e_be, e_bwd, e_res);
        check("ex_ready_idle", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        @(negedge clk);
        ex_valid = 1'b0; mem_read = 3'd0; mem_write = 2'd0; addr = $urandom; wdata = $urandom;
        if (flt) begin
            check("acc_fault_req", 32'(bus_req), 32'd0);
            check("acc_fault_valid", 32'(wb_valid), 32'd1);
            check("acc_fault_flag", 32'(fault), 32'd1);
            check("acc_fault_data", wb_rdata, FDATA);
            e_wb = FDATA;
            tmo  = 1'b1;
        end else begin
            ncyc = (ack_dly > TMO) ? TMO : ack_dly;
            for (int c = 1; c <= ncyc; c++) begin
                check("bus_req", 32'(bus_req), 32'd1);
                check("bus_addr", bus_addr, {a[31:2], 2'b00});
                check("bus_we", 32'(bus_we), 32'(wr != 0));
                check("bus_be", 32'(bus_be), 32'(e_be));
                if (wr != 0) check("bus_wdata", bus_wdata, e_bwd);
                check("bus_no_valid", 32'(wb_valid), 32'd0);
                if (c == ack_dly) begin
                    bus_ack = 1'b1; bus_rdata = rdata;
                end
                @(negedge clk);
                bus_ack = 1'b0; bus_rdata = $urandom;
            end
            tmo  = (ack_dly > TMO);
            e_wb = tmo ? FDATA : ((rd != 0) ? e_res : 32'h0);
            check("resp_valid", 32'(wb_valid), 32'd1);
            check("resp_req_low", 32'(bus_req), 32'd0);
            check("resp_fault", 32'(fault), 32'(tmo));
            check("resp_data", wb_rdata, e_wb);
        end
        @(negedge clk);
        check("valid_one_cycle", 32'(wb_valid), 32'd0);
        check("ex_ready_back", 32'(ex_ready), 32'd1);
        check("fault_hold", 32'(fault), 32'(tmo));
        check("rdata_hold", wb_rdata, e_wb);
    endtask

    task automatic run_nop();
        ex_valid = 1'b1; mem_read = 3'd0; mem_write = 2'd0; addr = $urandom;
        @(negedge clk);
        ex_valid = 1'b0;
        check("nop_ready", 32'(ex_ready), 32'd1);
        check("nop_req", 32'(bus_req), 32'd0);
        check("nop_valid", 32'(wb_valid), 32'd0);
    endtask

    logic [2:0]  r_rd;
    logic [1:0]  r_wr;
    logic [31:0] r_a;
    int          kind, dly;

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; mem_read = 3'd0; mem_write = 2'd0;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_wb_rdata", wb_rdata, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(3'd0, 2'd3, 32'h1004, 32'hDEADBEEF, 3, 32'h0);
        run_op(3'd1, 2'd0, 32'h1003, 32'h0, 1, 32'h80FF1234);
        run_op(3'd4, 2'd0, 32'h1003, 32'h0, 1, 32'h80FF1234);
        run_op(3'd2, 2'd0, 32'h1002, 32'h0, 1, 32'h80FF1234);
        run_op(3'd5, 2'd0, 32'h1002, 32'h0, 1, 32'h80FF1234);
        run_op(3'd3, 2'd0, 32'h0010, 32'h0, 1, 32'h80FF1234);
        run_op(3'd0, 2'd1, 32'h1001, 32'h000000A5, 2, 32'h0);
        run_op(3'd0, 2'd2, 32'h1002, 32'h0000BEEF, 1, 32'h0);
        run_op(3'd3, 2'd0, 32'h1002, 32'h0, 1, 32'h0);
        run_op(3'd2, 2'd0, 32'h1001, 32'h0, 1, 32'h0);
        run_op(3'd0, 2'd3, 32'h0100, 32'h12345678, 1, 32'h0);
        run_op(3'd3, 2'd0, 32'h3000, 32'h0, 1, 32'h0);
        run_op(3'd3, 2'd3, 32'h1000, 32'h0, 1, 32'h0);
        run_op(3'd3, 2'd0, 32'h1000, 32'h0, 100, 32'h0);
        run_op(3'd3, 2'd0, 32'h2ffc, 32'h0, 16, 32'hCAFEF00D);
        run_nop();

        // Stray ack in IDLE
        bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
        @(negedge clk);
        bus_ack = 1'b0;
        check("stray_ack_idle", 32'(wb_valid), 32'd0);
        check("stray_ack_ready", 32'(ex_ready), 32'd1);

        // Reset in the second BUS cycle
        ex_valid = 1'b1; mem_read = 3'd3; addr = 32'h1000;
        @(negedge clk);
        ex_valid = 1'b0; mem_read = 3'd0;
        check("mid_bus_c1", 32'(bus_req), 32'd1);
        @(negedge clk);
        check("mid_bus_c2", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(bus_req), 32'd0);
        check("rst_mid_ready", 32'(ex_ready), 32'd1);
        check("rst_mid_addr", bus_addr, 32'h0);
        check("rst_mid_rdata", wb_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h11112222;
        check("rel_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        bus_ack = 1'b0;
        check("late_ack_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("late_ack_valid2", 32'(wb_valid), 32'd0);
        check("late_ack_req", 32'(bus_req), 32'd0);

        // Random ops
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            r_rd = 3'd0; r_wr = 2'd0;
            if (kind <= 4) r_rd = 3'($urandom_range(1, 5));
            else if (kind <= 7) r_wr = 2'($urandom_range(1, 3));
            else if (kind == 8) begin
                r_rd = 3'($urandom_range(1, 5)); r_wr = 2'($urandom_range(1, 3));
            end
            case ($urandom_range(0, 3))
                0:       r_a = 32'($urandom_range(0, 32'h33ff));
                1:       r_a = 32'($urandom_range(32'h1000, 32'h2fff)) & 32'hffff_fffc;
                2:       r_a = $urandom;
                default: r_a = 32'($urandom_range(0, 32'h0fff));
            endcase
            dly = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 4);
            if (kind == 9) run_nop();
            else run_op(r_rd, r_wr, r_a, $urandom, dly, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the execute stage and the data-memory bus.
- Consumes the execute stage's `mem_read_t` / `mem_write_t` controls, effective address and store data.
- Checks alignment and the ROM/RAM address map, then issues one bus transaction using a req/ack handshake.
- Returns sign- or zero-extended load data, or an access fault, to writeback.

Parameters:
- `TIMEOUT_CYCLES`, 16: BUS-state cycles without `bus_ack` before a fault is raised; 0 disables the timeout.
- `FAULT_DATA`, 32'hdead_beef: value driven on `wb_rdata` for a faulted access.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  request from execute is present.
- `ex_ready`  out  1  unit can accept a request.
- `mem_read`  in  3  `mem_read_t` (NONE/BYTE/HALF/WORD/BYTE_U/HALF_U).
- `mem_write`  in  2  `mem_write_t` (NONE/BYTE/HALF/WORD).
- `addr`  in  32  byte effective address.
- `wdata`  in  32  store data, right-aligned.
- `wb_valid`  out  1  one-cycle completion pulse.
- `wb_rdata`  out  32  extended load data, or `FAULT_DATA` on fault.
- `fault`  out  1  access fault; qualified by `wb_valid`.
- `bus_req`  out  1  bus transaction request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word-aligned address (`addr[31:2]`, 2'b00).
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_be`  out  4  byte enables; 0 on reads.
- `bus_ack`  in  1  bus completion; read data valid in the same cycle.
- `bus_rdata`  in  32  read word.

Behaviour:
- Reset: `rst_n` low asynchronously forces state IDLE and clears the timeout counter and every register. Output values under reset:
  - `ex_ready` = 1.
  - `wb_valid`, `fault`, `bus_req`, `bus_we` = 0.
  - `bus_addr`, `bus_wdata`, `wb_rdata` = 0.
  - `bus_be` = 0.
- States: IDLE, BUS, RESP. `ex_ready` = 1 only in IDLE; `bus_req` = 1 only in BUS, decoded from the state register.
- Accept condition: IDLE && `ex_valid` && (`mem_read` != NONE || `mem_write` != NONE). On accept, latch the op, address and data. `ex_valid` with both NONE is ignored.
- Checks at accept; if any fails, go IDLE->RESP with `fault` = 1 and no bus access:
  - Both `mem_read` and `mem_write` non-NONE.
  - Halfword access with `addr[0]` = 1.
  - Word access with `addr[1:0]` != 0.
  - Load outside [0x0000_0000, 0x0000_3000).
  - Store outside [0x0000_1000, 0x0000_3000); the ROM region is read-only.
- Legal accept: IDLE->BUS.
- BUS state:
  - Hold all `bus_*` outputs stable until `bus_ack`.
  - On `bus_ack`, capture `bus_rdata`, go to RESP, `fault` = 0.
  - If the counter reaches `TIMEOUT_CYCLES` without `bus_ack`, go to RESP with `fault` = 1.
- RESP: `wb_valid` = 1 for exactly one cycle, then IDLE. `bus_ack` outside BUS is ignored.
- Latency: accept edge -> BUS next cycle. With `bus_ack` in the first BUS cycle, `wb_valid` comes 2 cycles after accept. A fault raised at accept gives `wb_valid` 1 cycle after accept. Throughput is one access per 3 cycles minimum.
- Store lanes:
  - SB: `bus_be` = 4'b0001 << `addr[1:0]`; `bus_wdata` = `{4{wdata[7:0]}}`.
  - SH: `bus_be` = 4'b0011 or 4'b1100 selected by `addr[1]`; `bus_wdata` = `{2{wdata[15:0]}}`.
  - SW: `bus_be` = 4'b1111; `bus_wdata` = `wdata`.
- Load extract: select the byte or half lane by `addr[1:0]`. BYTE/HALF sign-extend; BYTE_U/HALF_U zero-extend; WORD passes through.
- Stores: `wb_rdata` = 0 on success.
- Faults: `wb_rdata` = `FAULT_DATA`.
- `wb_rdata` and `fault` hold their value until the next RESP.
- Reset mid-transaction: `bus_req` drops immediately and the request is discarded. A late `bus_ack` arriving after reset is ignored.

Test Plan:
- SW `addr` 0x1004, `wdata` 0xDEADBEEF, `bus_ack` in the 3rd BUS cycle -> `bus_addr` 0x1004, `bus_be` 1111, `bus_we` 1; `wb_valid` one cycle after ack, `fault` 0, `ex_ready` back to 1 the next cycle.
- Loads with `bus_rdata` 0x80FF1234:
  - LB @0x1003 -> 0xFFFFFF80.
  - LBU @0x1003 -> 0x00000080.
  - LH @0x1002 -> 0xFFFF80FF.
  - LHU @0x1002 -> 0x000080FF.
  - LW @0x0010 (ROM) -> 0x80FF1234.
- SB @0x1001 `wdata` 0x000000A5 -> `bus_be` 0010, `bus_wdata` 0xA5A5A5A5. SH @0x1002 `wdata` 0x0000BEEF -> `bus_be` 1100, `bus_wdata` 0xBEEFBEEF.
- Faults (each: `bus_req` never asserted, `wb_valid` and `fault` 1 the cycle after accept, `wb_rdata` 0xDEADBEEF):
  - LW @0x1002.
  - LH @0x1001.
  - SW @0x0100.
  - LW @0x3000.
  - Both `mem_read` and `mem_write` non-NONE.
- Timeout: LW @0x1000 with no ack -> `bus_req` high for 16 cycles, then `wb_valid`/`fault` = 1, `bus_req` 0. A back-to-back request is accepted in the IDLE cycle that follows.
- Pull `rst_n` low in the 2nd BUS cycle -> `bus_req` 0 in the same cycle. After release, `ex_ready` = 1; a stray `bus_ack` produces no `wb_valid`.
